ahb_spm: RTL
============

AHB_SPM -- requirements
Module: ahb_spm

Interface
REQ-001 SHALL provide parameter: ADDR_W, 10, word-address width; capacity is 2^ADDR_W 64-bit words (8 KiB at default).
REQ-002 SHALL provide port: HCLK  in  1  bus clock; the single clock, all state on rising edge.
REQ-003 SHALL provide port: HRESETn  in  1  reset; asynchronous, active-low.
REQ-004 SHALL provide port: HSEL  in  1  slave select from system AHB decoder.
REQ-005 SHALL provide port: HADDR  in  32  byte address; HADDR[ADDR_W+2:3] is the word index, higher bits ignored.
REQ-006 SHALL provide ports: HWRITE in 1, HTRANS in 2, HSIZE in 3, HBURST in 3, HMASTLOCK in 1; standard AHB-Lite meanings.
REQ-007 SHALL provide port: HWDATA  in  64  write data, byte lane k = HWDATA[8k+7:8k] for byte address offset k.
REQ-008 SHALL provide port: HREADY  out  1  transfer-done / address-phase-accept.
REQ-009 SHALL provide port: HRESP  out  1  0=OKAY, 1=ERROR.
REQ-010 SHALL provide port: HRDATA  out  64  full read word, all lanes driven.

Function
REQ-011 SHALL accept an address phase on a rising edge where HSEL=1, HTRANS[1]=1 and HREADY=1; no separate HREADY input exists.
REQ-012 SHALL treat IDLE/BUSY or HSEL=0 as no-operation: OKAY, zero wait, no memory access; HBURST and HMASTLOCK ignored (bursts handled as single beats).
REQ-013 SHALL use state machine IDLE, DATA, RAW, ERR1, ERR2.
REQ-014 SHALL check on accept: HSIZE>3, or HADDR not aligned to 2^HSIZE bytes -> ERR1; otherwise DATA.
REQ-015 SHALL in ERR1 drive HREADY=0, HRESP=1, then ERR2 drive HREADY=1, HRESP=1; no memory read or write occurs.
REQ-016 SHALL form byte strobes from latched HSIZE/HADDR[2:0]: size0 1 byte, size1 2 bytes, size2 4 bytes, size3 all 8.
REQ-017 SHALL commit writes at the end of the data phase (edge where HREADY=1) using HWDATA and strobes; unstrobed bytes unchanged.
REQ-018 SHALL issue reads to a 1R1W synchronous RAM at the address-phase edge; HRDATA valid in data phase with zero wait states.
REQ-019 SHALL, when a read is accepted while a write data phase to the same word index is completing, enter RAW: HREADY=0 one cycle, re-read RAM, then DATA with merged (new) data; different word index -> no stall.
REQ-020 SHALL hold HRDATA at its last valid value in all cycles other than a completing read data phase.
REQ-021 SHALL allow back-to-back pipelined transfers: a new address phase is accepted in the same cycle a data phase completes.
REQ-022 SHALL wrap word index modulo 2^ADDR_W (no error for addresses above capacity inside the selected region).
REQ-023 SHALL keep write and read to a word in the same cycle deterministic only via REQ-019; no other ordering hazards exist.

Reset
REQ-024 SHALL, on HRESETn low at any time, immediately force state IDLE, HREADY=1, HRESP=0, HRDATA=0, and discard any pending write.
REQ-025 SHALL NOT reset or initialise RAM contents; reads of unwritten words return undefined data.
REQ-026 SHALL resume accepting transfers on the first rising edge after HRESETn deasserts.

Verification
REQ-027 SHALL pass: 64-bit write 0x1122334455667788 to 0x0008, read 0x0008 -> HRDATA 0x1122334455667788, OKAY, zero wait each.
REQ-028 SHALL pass: write word 0x0 to all-ones, byte write 0xAB at 0x0003 (lane 3) -> read 0x0 returns 0xFFFFFFFFABFFFFFF.
REQ-029 SHALL pass: write 0xDEADBEEF00000000 to 0x0010 immediately followed by read 0x0010 -> exactly one HREADY=0 cycle, read returns new value; same with read 0x0018 -> no stall.
REQ-030 SHALL pass: halfword access at 0x0001, or HSIZE=4 -> HREADY=0/HRESP=1 then HREADY=1/HRESP=1, target word unchanged on readback.
REQ-031 SHALL pass: write to 0x2008 with ADDR_W=10 -> readback at 0x0008 returns the written value (wrap).
REQ-032 SHALL pass: HRESETn asserted during ERR1 or RAW -> outputs HREADY=1, HRESP=0, HRDATA=0 asynchronously, pending write not committed.

Source files
------------

// File: rtl/ahb_spm.sv
// AHB-Lite 64-bit scratchpad memory: single-cycle reads and writes, byte strobes,
// read-after-write stall on the same word, and a two-cycle ERROR response for bad size or alignment.
module ahb_spm #(
    parameter int ADDR_W = 10
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [63:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [63:0] HRDATA,
    output logic [2:0]  dbg_state
);

    // Handshake: an address phase is taken on a rising edge with HSEL=1, HTRANS[1]=1 and HREADY=1.
    // Its data phase ends on the first later rising edge with HREADY=1.
    typedef enum logic [2:0] {S_IDLE, S_DATA, S_RAW, S_ERR1, S_ERR2} state_t;

    state_t              state, state_n;
    logic [63:0]         mem [0:(1<<ADDR_W)-1];
    logic                d_write;
    logic [ADDR_W-1:0]   d_idx;
    logic [1:0]          d_size;
    logic [2:0]          d_off;
    logic [ADDR_W-1:0]   addr_idx, rd_idx;
    logic [7:0]          strb;
    logic                accept, addr_err, wr_commit, raw_hit, rd_en;
    logic                unused_ok;

    assign unused_ok = ^{HBURST, HMASTLOCK, HTRANS[0], HADDR[31:ADDR_W+3]};
    assign addr_idx  = HADDR[ADDR_W+2:3];
    assign dbg_state = state;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        case (state)
            S_RAW:   HREADY = 1'b0;
            S_ERR1:  begin HREADY = 1'b0; HRESP = 1'b1; end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (HSIZE)
            3'd0:    addr_err = 1'b0;
            3'd1:    addr_err = HADDR[0];
            3'd2:    addr_err = |HADDR[1:0];
            3'd3:    addr_err = |HADDR[2:0];
            default: addr_err = 1'b1;
        endcase
    end

    // A read that hits the word being written this edge must wait one cycle for the merged data.
    assign accept    = HSEL && HTRANS[1] && HREADY;
    assign wr_commit = (state == S_DATA) && d_write;
    assign raw_hit   = accept && !addr_err && !HWRITE && wr_commit && (addr_idx == d_idx);
    assign rd_en     = (accept && !addr_err && !HWRITE && !raw_hit) || (state == S_RAW);
    assign rd_idx    = (state == S_RAW) ? d_idx : addr_idx;

    always_comb begin
        case (d_size)
            2'd0:    strb = 8'h01 << d_off;
            2'd1:    strb = 8'h03 << d_off;
            2'd2:    strb = 8'h0f << d_off;
            default: strb = 8'hff;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_RAW:   state_n = S_DATA;
            S_ERR1:  state_n = S_ERR2;
            default: begin
                if (!accept)      state_n = S_IDLE;
                else if (addr_err) state_n = S_ERR1;
                else if (raw_hit)  state_n = S_RAW;
                else               state_n = S_DATA;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            d_write <= 1'b0;
            d_idx   <= '0;
            d_size  <= 2'd0;
            d_off   <= 3'd0;
            HRDATA  <= 64'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                d_write <= HWRITE && !addr_err;
                d_idx   <= addr_idx;
                d_size  <= HSIZE[1:0];
                d_off   <= HADDR[2:0];
            end
            if (rd_en) HRDATA <= mem[rd_idx];
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mem[d_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule
